// File: rtl/mem_copy_engine.sv
// Word-granular block-copy initiator: reads a source word over the memory's
// combinational read path, then writes it to the destination, one word per two cycles.
module mem_copy_engine #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic [31:0]        srcAddr,
    input  logic [31:0]        dstAddr,
    input  logic [COUNT_W-1:0] wordCount,
    output logic [31:0]        memAddr,
    output logic               memWrEn,
    output logic [31:0]        memDataOut,
    input  logic [31:0]        memDataIn,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] wordsDone
);

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_src_q, cur_src_d;
    logic [ADDR_W-1:0]   cur_dst_q, cur_dst_d;
    logic [COUNT_W-1:0]  remaining_q, remaining_d;
    logic [COUNT_W-1:0]  words_done_q, words_done_d;
    logic [DATA_W-1:0]   data_buf_q, data_buf_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [DATA_W-1:0]   mem_data_out_q, mem_data_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state logic; memory-side outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_d        = state_q;
        cur_src_d      = cur_src_q;
        cur_dst_d      = cur_dst_q;
        remaining_d    = remaining_q;
        words_done_d   = words_done_q;
        data_buf_d     = data_buf_q;
        mem_addr_d     = '0;
        mem_wr_en_d    = 1'b0;
        mem_data_out_d = '0;
        busy_d         = 1'b0;
        done_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_src_d    = srcAddr & ALIGN_MASK;
                    cur_dst_d    = dstAddr & ALIGN_MASK;
                    remaining_d  = wordCount;
                    words_done_d = '0;
                    state_d      = (wordCount == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                data_buf_d = memDataIn;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                cur_src_d    = cur_src_q + WORD_BYTES;
                cur_dst_d    = cur_dst_q + WORD_BYTES;
                remaining_d  = remaining_q - COUNT_W'(1);
                words_done_d = words_done_q + COUNT_W'(1);
                state_d      = (remaining_q == COUNT_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_READ: begin
                mem_addr_d = cur_src_d;
            end
            S_WRITE: begin
                mem_addr_d     = cur_dst_d;
                mem_wr_en_d    = 1'b1;
                mem_data_out_d = data_buf_d;
            end
            default: begin
                mem_addr_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= S_IDLE;
            cur_src_q      <= '0;
            cur_dst_q      <= '0;
            remaining_q    <= '0;
            words_done_q   <= '0;
            data_buf_q     <= '0;
            mem_addr_q     <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_data_out_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_src_q      <= cur_src_d;
            cur_dst_q      <= cur_dst_d;
            remaining_q    <= remaining_d;
            words_done_q   <= words_done_d;
            data_buf_q     <= data_buf_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_data_out_q <= mem_data_out_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Reset asserted during a WRITE cycle must suppress that cycle's commit at the memory.
    assign memWrEn    = mem_wr_en_q & resetN;
    assign memAddr    = mem_addr_q;
    assign memDataOut = mem_data_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wordsDone  = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: small aliased word memory, array-copy reference model,
// cycle-by-cycle interface checks, directed scenarios plus randomized copies.
module tb_mem_copy_engine;

    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned MEM_WORDS = 1024;

    logic               clk = 1'b0;
    logic               resetN;
    logic               start;
    logic [31:0]        srcAddr;
    logic [31:0]        dstAddr;
    logic [COUNT_W-1:0] wordCount;
    logic [31:0]        memAddr;
    logic               memWrEn;
    logic [31:0]        memDataOut;
    logic [31:0]        memDataIn;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] wordsDone;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    logic        fill_en;
    logic [31:0] fill_seed;
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_copy_engine #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .srcAddr    (srcAddr),
        .dstAddr    (dstAddr),
        .wordCount  (wordCount),
        .memAddr    (memAddr),
        .memWrEn    (memWrEn),
        .memDataOut (memDataOut),
        .memDataIn  (memDataIn),
        .busy       (busy),
        .done       (done),
        .wordsDone  (wordsDone)
    );

    always #5 clk = ~clk;

    // 4 KB memory: byte address aliases modulo 4096, identically in memory and model.
    function automatic logic [9:0] widx(input logic [31:0] a);
        return 10'((a >> 2) & 32'h3FF);
    endfunction

    function automatic logic [31:0] fill_val(input int i, input logic [31:0] seed);
        return (32'(i) * 32'h9E37_79B1) ^ seed;
    endfunction

    assign memDataIn = mem[widx(memAddr)];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= fill_val(i, fill_seed);
        end else if (memWrEn) begin
            mem[widx(memAddr)] <= memDataOut;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input logic [31:0] seed);
        @(negedge clk);
        fill_en = 1'b1;
        fill_seed = seed;
        @(posedge clk);
        #1;
        fill_en = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = fill_val(i, seed);
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1;
        pl_idx = widx(addr);
        pl_data = data;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[widx(addr)] = data;
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, " mem_bad_words"}, 32'(bad), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " memAddr"},    memAddr,          32'd0);
        check({tag, " memWrEn"},    32'(memWrEn),     32'd0);
        check({tag, " memDataOut"}, memDataOut,       32'd0);
        check({tag, " busy"},       32'(busy),        32'd0);
        check({tag, " done"},       32'(done),        32'd0);
        check({tag, " wordsDone"},  32'(wordsDone),   32'd0);
    endtask

    // One copy; abort_c / ign_c = cycle (after acceptance) in which reset is dropped /
    // a stray start is pulsed, 0 = none. Returns while the engine is idle.
    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int n, input int abort_c, input int ign_c);
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] exp_addr;
        logic [31:0] exp_dout;
        logic        exp_we;
        logic        exp_busy;
        logic        exp_done;
        int          exp_wd;
        int          k;
        int          last;
        string       t;
        s = src & ~32'd3;
        d = dst & ~32'd3;
        last = 2 * n + 2;

        @(negedge clk);
        start = 1'b1;
        srcAddr = src;
        dstAddr = dst;
        wordCount = COUNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        srcAddr = $urandom;
        dstAddr = $urandom;
        wordCount = COUNT_W'($urandom);

        for (int c = 1; c <= last; c++) begin
            t = $sformatf("%s c%0d", name, c);
            k = (c - 1) / 2;
            exp_busy = (c <= 2 * n + 1);
            exp_done = (c == 2 * n + 1);
            exp_we   = 1'b0;
            exp_addr = 32'd0;
            exp_dout = 32'd0;
            if (c <= 2 * n) begin
                if (c % 2 == 1) begin
                    exp_addr = s + 32'(4 * k);
                end else begin
                    exp_addr = d + 32'(4 * k);
                    exp_we   = 1'b1;
                    exp_dout = ref_mem[widx(s + 32'(4 * k))];
                end
            end
            exp_wd = (k > n) ? n : k;

            check({t, " memAddr"},    memAddr,        exp_addr);
            check({t, " memWrEn"},    32'(memWrEn),   32'(exp_we));
            check({t, " memDataOut"}, memDataOut,     exp_dout);
            check({t, " busy"},       32'(busy),      32'(exp_busy));
            check({t, " done"},       32'(done),      32'(exp_done));
            check({t, " wordsDone"},  32'(wordsDone), 32'(exp_wd));

            if (exp_we && c != abort_c) ref_mem[widx(d + 32'(4 * k))] = exp_dout;

            if (ign_c != 0 && c == ign_c) begin
                start = 1'b1;
                srcAddr = 32'd0;
            end else if (ign_c != 0 && c == ign_c + 1) begin
                start = 1'b0;
            end

            if (c == abort_c) begin
                resetN = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b0;
                check_reset_outputs({t, " after_reset"});
                resetN = 1'b1;
                break;
            end
            if (c < last) begin
                @(posedge clk);
                #1;
            end
        end
        compare_mem(name);
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rd;
        int          rn;
        int          ra;
        int          ri;

        resetN = 1'b0;
        start = 1'b0;
        srcAddr = 32'd0;
        dstAddr = 32'd0;
        wordCount = '0;
        fill_en = 1'b0;
        fill_seed = 32'd0;
        pl_en = 1'b0;
        pl_idx = '0;
        pl_data = 32'd0;

        fill_mem(32'h1357_9BDF);
        @(posedge clk);
        #1;
        check_reset_outputs("init_reset");
        resetN = 1'b1;

        for (int i = 0; i < 4; i++) poke(32'd64 + 32'(4 * i), 32'hA0 + 32'(i));
        run_copy("basic4", 32'd64, 32'd256, 4, 0, 0);
        check("basic4 word256", mem[widx(32'd256)], 32'hA0);
        check("basic4 word268", mem[widx(32'd268)], 32'hA3);
        check("basic4 src64",   mem[widx(32'd64)],  32'hA0);

        run_copy("zero", 32'd128, 32'd384, 0, 0, 0);

        poke(32'd64, 32'h1234);
        run_copy("misalign", 32'd66, 32'd259, 1, 0, 0);
        check("misalign word256", mem[widx(32'd256)], 32'h1234);

        poke(32'd0, 32'hBEEF);
        run_copy("overlap", 32'd0, 32'd4, 3, 0, 0);
        check("overlap word12", mem[widx(32'd12)], 32'hBEEF);

        fill_mem(32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) poke(32'd64 + 32'(4 * i), 32'hA0 + 32'(i));
        run_copy("ignore_start", 32'd64, 32'd256, 4, 0, 3);
        fill_mem(32'h2468_ACE0);
        for (int i = 0; i < 4; i++) poke(32'd64 + 32'(4 * i), 32'hA0 + 32'(i));
        run_copy("abort", 32'd64, 32'd256, 4, 5, 3);
        check("abort word260", mem[widx(32'd260)], 32'hA1);
        check("abort word264", mem[widx(32'd264)], fill_val(66, 32'h2468_ACE0));

        run_copy("wrap", 32'hFFFF_FFFC, 32'd512, 2, 0, 0);

        for (int it = 0; it < 30; it++) begin
            rs = $urandom;
            rd = ($urandom_range(0, 1) == 1) ? rs + 32'(4 * $urandom_range(0, 3)) : $urandom;
            rn = $urandom_range(0, 12);
            ra = ($urandom_range(0, 4) == 0 && rn > 0) ? $urandom_range(1, 2 * rn + 1) : 0;
            ri = ($urandom_range(0, 2) == 0 && rn > 0) ? $urandom_range(1, 2 * rn) : 0;
            if ($urandom_range(0, 7) == 0) fill_mem($urandom);
            run_copy($sformatf("rnd%0d", it), rs, rd, rn, ra, ri);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
